// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the data memory
// and the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_ack;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_wd;
  logic [DW-1:0] ld_rd;
  logic          ld_ack;

  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic [1:0]    gnt;

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_ack,
    output ld_req, ld_we, ld_adr, ld_wd,
    input  ld_rd, ld_ack,
    input  mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  gnt
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_ack,
    input  ld_req, ld_we, ld_adr, ld_wd,
    output ld_rd, ld_ack,
    output mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output gnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU vs loader, round-robin on ties
// with a burst limit so neither side starves.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    LD   = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_ld, last_ld_n;
  logic          sat;

  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wd;
  logic          sel_we;
  logic          cack;
  logic          lack;
  logic [1:0]    sel_gnt;

  assign sat = (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_ld <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last_ld <= last_ld_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          bus.cpu_req && !bus.ld_req:
            state_n = CPU;
          bus.ld_req && !bus.cpu_req:
            state_n = LD;
          bus.cpu_req && bus.ld_req:
            state_n = last_ld ? CPU : LD;
          default:
            state_n = IDLE;
        endcase
      end
      CPU: begin
        if (!bus.cpu_req)
          state_n = bus.ld_req ? LD : IDLE;
        else if (bus.ld_req && sat)
          state_n = LD;
      end
      LD: begin
        if (!bus.ld_req)
          state_n = bus.cpu_req ? CPU : IDLE;
        else if (bus.cpu_req && sat)
          state_n = CPU;
      end
      default: state_n = IDLE;
    endcase

    cnt_n     = cnt;
    last_ld_n = last_ld;
    if (state_n != state) begin
      cnt_n = '0;
      if (state_n == CPU)
        last_ld_n = 1'b0;
      else if (state_n == LD)
        last_ld_n = 1'b1;
    end else if (state_n != IDLE && !sat) begin
      cnt_n = cnt + 1'b1;
    end
  end

  // reset aborts an in-flight access: no ack, no write at that edge
  always_comb begin
    sel_adr = '0;
    sel_wd  = '0;
    sel_we  = 1'b0;
    cack    = 1'b0;
    lack    = 1'b0;
    sel_gnt = 2'b00;
    unique case (state)
      CPU: begin
        sel_gnt = 2'b01;
        sel_adr = bus.cpu_adr;
        sel_wd  = bus.cpu_wd;
        cack    = bus.cpu_req & ~reset;
        sel_we  = bus.cpu_we & cack;
      end
      LD: begin
        sel_gnt = 2'b10;
        sel_adr = bus.ld_adr;
        sel_wd  = bus.ld_wd;
        lack    = bus.ld_req & ~reset;
        sel_we  = bus.ld_we & lack;
      end
      default: ;
    endcase
  end

  assign bus.mem_adr = sel_adr;
  assign bus.mem_wd  = sel_wd;
  assign bus.mem_we  = sel_we;
  assign bus.cpu_ack = cack;
  assign bus.ld_ack  = lack;
  assign bus.gnt     = sel_gnt;
  assign bus.cpu_rd  = bus.mem_rd;
  assign bus.ld_rd   = bus.mem_rd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory
// behind the arbiter's memory port.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(
    .AW(32),
    .DW(32),
    .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;
  int          wecnt = 0;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_idx] <= pre_val;
    else if (bus.mem_we)
      mem[bus.mem_adr[9:2]] <= bus.mem_wd;
    if (bus.mem_we)
      wecnt <= wecnt + 1;
  end

  assign bus.mem_rd = mem[bus.mem_adr[9:2]];

  int nvec = 0;
  int nerr = 0;
  int base;

  logic [14:0] creq, lreq, cexp, lexp;
  logic [1:0]  gexp [15];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.cpu_adr = '0;
    bus.cpu_wd  = '0;
    bus.ld_req  = 1'b0;
    bus.ld_we   = 1'b0;
    bus.ld_adr  = '0;
    bus.ld_wd   = '0;
  endtask

  initial begin
    clr();
    reset   = 1'b1;
    pre_we  = 1'b1;
    pre_idx = 8'h10;
    pre_val = 32'hDEAD_BEEF;
    @(negedge clk);
    pre_we = 1'b0;

    // outputs stay quiet in reset even with live requests
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    bus.cpu_adr = 32'h44;
    bus.cpu_wd  = 32'h5;
    bus.ld_req  = 1'b1;
    bus.ld_wd   = 32'h77;
    #1;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_cack", bus.cpu_ack, 1'b0);
    chk("rst_lack", bus.ld_ack, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_adr", bus.mem_adr, 32'h0);
    chk("rst_wd", bus.mem_wd, 32'h0);
    clr();
    @(negedge clk);
    reset = 1'b0;

    bus.cpu_req = 1'b1;
    bus.cpu_adr = 32'h40;
    #1;
    chk("t1_lat_ack", bus.cpu_ack, 1'b0);
    chk("t1_lat_gnt", bus.gnt, 2'b00);
    @(negedge clk); #1;
    chk("t1_ack", bus.cpu_ack, 1'b1);
    chk("t1_gnt", bus.gnt, 2'b01);
    chk("t1_rd", bus.cpu_rd, 32'hDEAD_BEEF);
    chk("t1_we", bus.mem_we, 1'b0);
    chk("t1_adr", bus.mem_adr, 32'h40);
    chk("t1_lack", bus.ld_ack, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("t1_drop_ack", bus.cpu_ack, 1'b0);
    chk("t1_drop_gnt", bus.gnt, 2'b01);
    @(negedge clk); #1;
    chk("t1_idle", bus.gnt, 2'b00);

    base = wecnt;
    bus.ld_req = 1'b1;
    bus.ld_we  = 1'b1;
    bus.ld_adr = 32'h80;
    bus.ld_wd  = 32'h1234_5678;
    @(negedge clk); #1;
    chk("t2_lack", bus.ld_ack, 1'b1);
    chk("t2_gnt", bus.gnt, 2'b10);
    chk("t2_we", bus.mem_we, 1'b1);
    chk("t2_adr", bus.mem_adr, 32'h80);
    chk("t2_wd", bus.mem_wd, 32'h1234_5678);
    chk("t2_cack", bus.cpu_ack, 1'b0);
    @(negedge clk);
    bus.ld_req  = 1'b0;
    bus.ld_we   = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_adr = 32'h80;
    #1;
    chk("t2_we_off", bus.mem_we, 1'b0);
    chk("t2_wcnt", wecnt - base, 1);
    @(negedge clk); #1;
    chk("t2_cack2", bus.cpu_ack, 1'b1);
    chk("t2_rd", bus.cpu_rd, 32'h1234_5678);
    chk("t2_gnt2", bus.gnt, 2'b01);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("t2_wcnt2", wecnt - base, 1);
    chk("t2_idle", bus.gnt, 2'b00);

    // tie straight after reset: CPU first
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_adr = 32'h40;
    bus.ld_req  = 1'b1;
    bus.ld_adr  = 32'h80;
    #1;
    chk("t3_idle", bus.gnt, 2'b00);
    @(negedge clk); #1;
    chk("t3_cfirst", bus.cpu_ack, 1'b1);
    chk("t3_lwait", bus.ld_ack, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("t3_lwait2", bus.ld_ack, 1'b0);
    @(negedge clk); #1;
    chk("t3_lack", bus.ld_ack, 1'b1);
    chk("t3_lgnt", bus.gnt, 2'b10);
    chk("t3_lrd", bus.ld_rd, 32'h1234_5678);
    @(negedge clk);
    bus.ld_req  = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // CPU was last: tie now goes to the loader
    bus.cpu_req = 1'b1;
    bus.ld_req  = 1'b1;
    @(negedge clk); #1;
    chk("t3_lfirst", bus.ld_ack, 1'b1);
    chk("t3_cwait", bus.cpu_ack, 1'b0);
    chk("t3_gnt_ld", bus.gnt, 2'b10);
    @(negedge clk);
    bus.ld_req = 1'b0;
    @(negedge clk); #1;
    chk("t3_cnext", bus.cpu_ack, 1'b1);
    chk("t3_gnt_cpu", bus.gnt, 2'b01);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // burst limit and parked CPU grant
    creq = 15'h3FFF;
    lreq = 15'h183C;
    cexp = 15'h0F9E;
    lexp = 15'h1020;
    gexp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
             2'd2, 2'd2, 2'd1, 2'd1, 2'd1,
             2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
    bus.cpu_adr = 32'h40;
    bus.ld_adr  = 32'h80;
    for (int k = 0; k < 15; k++) begin
      bus.cpu_req = creq[k];
      bus.ld_req  = lreq[k];
      #1;
      chk($sformatf("t4_cack[%0d]", k),
          bus.cpu_ack, cexp[k]);
      chk($sformatf("t4_lack[%0d]", k),
          bus.ld_ack, lexp[k]);
      chk($sformatf("t4_gnt[%0d]", k),
          bus.gnt, gexp[k]);
      chk($sformatf("t4_excl[%0d]", k),
          bus.cpu_ack & bus.ld_ack, 1'b0);
      @(negedge clk);
    end
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    #1;
    chk("t4_idle", bus.gnt, 2'b00);

    // reset in the middle of a loader write
    base = wecnt;
    bus.ld_req = 1'b1;
    bus.ld_we  = 1'b1;
    bus.ld_adr = 32'h84;
    bus.ld_wd  = 32'hCAFE_0001;
    @(negedge clk); #1;
    chk("t6_lack", bus.ld_ack, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_rst_lack", bus.ld_ack, 1'b0);
    chk("t6_rst_we", bus.mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_gnt", bus.gnt, 2'b00);
    chk("t6_lack2", bus.ld_ack, 1'b0);
    chk("t6_we2", bus.mem_we, 1'b0);
    chk("t6_wcnt0", wecnt - base, 0);
    @(negedge clk); #1;
    chk("t6_re_lack", bus.ld_ack, 1'b1);
    chk("t6_re_we", bus.mem_we, 1'b1);
    @(negedge clk);
    bus.ld_req  = 1'b0;
    bus.ld_we   = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_adr = 32'h84;
    #1;
    chk("t6_wcnt1", wecnt - base, 1);
    @(negedge clk); #1;
    chk("t6_cack", bus.cpu_ack, 1'b1);
    chk("t6_rd", bus.cpu_rd, 32'hCAFE_0001);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
